shared_arith_scheduler: RTL and testbench

//  Time-multiplexed evaluator for the six-expression commutativity/subexpression set
//  (out1=X*Y+(Z+P), out2=(P+Z)*(Q-R), out3=Y+S+X+T, out4=(Y*X+Q)*(P+X),
//   out5=(X*Y+P)-(R+P+X), out6=(X+Y+P)*(Q-R)) using ONE multiplier and ONE add/sub unit.

---
 rtl/shared_arith_scheduler.sv | 142 ++++++++++++++
 tb/tb_shared_arith_scheduler.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/shared_arith_scheduler.sv
// Six-expression evaluator time-sharing one multiplier and one add/sub unit over a 12-step schedule.
// Optional macro PIPE_MUL_EN adds a pipeline register behind the multiplier.
module shared_arith_scheduler #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] t,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, next_state;
  logic [3:0]       step;
  logic [WIDTH-1:0] xr, yr, zr, pr, qr, rr, sr, tr;
  logic [WIDTH-1:0] m, a, d, xp, u, v, w, k, j, j2;
  logic [WIDTH-1:0] mul_a, mul_b, add_a, add_b, prod, add_res, mul_val;
  logic             sub;
  logic [3:0]       mul_step;
  logic             calc_en;

  assign in_ready = (state == IDLE);
  assign busy     = (state == CALC) || (state == DONE);
  assign calc_en  = (state == CALC) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid) next_state = CALC;
      CALC: if (abort) next_state = IDLE;
            else if (step == 4'd11) next_state = DONE;
      DONE: if (abort || (out_valid && out_ready)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand routing for the shared units, indexed by schedule step
  always_comb begin
    mul_a = '0; mul_b = '0; add_a = '0; add_b = '0; sub = 1'b0;
    case (step)
      4'd0:  begin mul_a = xr; mul_b = yr; add_a = zr; add_b = pr; end
      4'd1:  begin add_a = qr; add_b = rr; sub = 1'b1; end
      4'd2:  begin mul_a = a;  mul_b = d;  add_a = m;  add_b = a;  end
      4'd3:  begin add_a = xr; add_b = pr; end
      4'd4:  begin add_a = m;  add_b = qr; end
      4'd5:  begin mul_a = u;  mul_b = xp; add_a = m;  add_b = pr; end
      4'd6:  begin add_a = xp; add_b = rr; end
      4'd7:  begin add_a = v;  add_b = w;  sub = 1'b1; end
      4'd8:  begin add_a = xp; add_b = yr; end
      4'd9:  begin mul_a = k;  mul_b = d;  add_a = yr; add_b = sr; end
      4'd10: begin add_a = j;  add_b = xr; end
      4'd11: begin add_a = j2; add_b = tr; end
      default: ;
    endcase
  end

  assign prod    = mul_a * mul_b;
  assign add_res = sub ? (add_a - add_b) : (add_a + add_b);

`ifdef PIPE_MUL_EN
  logic [WIDTH-1:0] mul_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mul_pipe <= '0;
    else        mul_pipe <= prod;
  end

  // Products land one step after issue; every consumer is scheduled late enough
  assign mul_val  = mul_pipe;
  assign mul_step = step - 4'd1;
`else
  assign mul_val  = prod;
  assign mul_step = step;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= '0;
      {xr, yr, zr, pr, qr, rr, sr, tr} <= '0;
      {m, a, d, xp, u, v, w, k, j, j2} <= '0;
      {out1, out2, out3, out4, out5, out6} <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state == DONE) && !abort && !(out_valid && out_ready);
      if (state == IDLE && in_valid) begin
        step <= '0;
        xr <= x; yr <= y; zr <= z; pr <= p; qr <= q; rr <= r; sr <= s; tr <= t;
      end else if (state == CALC) begin
        step <= step + 4'd1;
      end
      if (calc_en) begin
        case (step)
          4'd0:  a    <= add_res;
          4'd1:  d    <= add_res;
          4'd2:  out1 <= add_res;
          4'd3:  xp   <= add_res;
          4'd4:  u    <= add_res;
          4'd5:  v    <= add_res;
          4'd6:  w    <= add_res;
          4'd7:  out5 <= add_res;
          4'd8:  k    <= add_res;
          4'd9:  j    <= add_res;
          4'd10: j2   <= add_res;
          4'd11: out3 <= add_res;
          default: ;
        endcase
        case (mul_step)
          4'd0: m    <= mul_val;
          4'd2: out2 <= mul_val;
          4'd5: out4 <= mul_val;
          4'd9: out6 <= mul_val;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shared_arith_scheduler.sv
// Directed bench for shared_arith_scheduler: latency, results, stall, abort, async reset, back-to-back.
module tb_shared_arith_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [31:0] x = '0, y = '0, z = '0, p = '0, q = '0, r = '0, s = '0, t = '0;
  logic [31:0] out1, out2, out3, out4, out5, out6;
  int          total = 0;
  int          bad = 0;

  shared_arith_scheduler #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z), .p(p), .q(q), .r(r), .s(s), .t(t),
    .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5), .out6(out6),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [31:0] vx, vy, vz, vp, vq, vr, vs, vt);
    x = vx; y = vy; z = vz; p = vp; q = vq; r = vr; s = vs; t = vt;
  endtask

  // Raise in_valid, wait for the accepting edge, then drop it in the step-0 cycle
  task automatic apply_stimulus(input logic [31:0] vx, vy, vz, vp, vq, vr, vs, vt);
    @(negedge clk);
    set_ops(vx, vy, vz, vp, vq, vr, vs, vt);
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("accept_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    set_ops('1, '1, '1, '1, '1, '1, '1, '1);
  endtask

  // Count edges from the accepting edge until out_valid, bounded
  task automatic wait_done();
    int cycles = 1;
    while (!out_valid && cycles < 40) begin
      @(posedge clk); #1;
      if (!out_valid) cycles++;
    end
    check("latency", cycles, 32'd13);
  endtask

  task automatic check_output(input logic [31:0] e1, e2, e3, e4, e5, e6);
    check("out1", out1, e1);
    check("out2", out2, e2);
    check("out3", out3, e3);
    check("out4", out4, e4);
    check("out5", out5, e5);
    check("out6", out6, e6);
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_out_valid", {31'b0, out_valid}, 32'd0);
    check("hs_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic seen;
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check_output('0, '0, '0, '0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic job, then hold results while a second job waits on in_valid
    apply_stimulus(2, 3, 4, 5, 10, 7, 1, 6);
    wait_done();
    check_output(15, 27, 12, 112, 32'hFFFF_FFFD, 30);
    @(negedge clk);
    set_ops(32'h0001_0000, 32'h0001_0000, 1, 2, 10, 7, 1, 6);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_out5", out5, 32'hFFFF_FFFD);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("b2b_hs_valid", {31'b0, out_valid}, 32'd0);
    check("b2b_idle_ready", {31'b0, in_ready}, 32'd1);
    check("hold_out1", out1, 32'd15);
    @(posedge clk); #1;
    check("b2b_accept", {31'b0, busy}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_ops('1, '1, '1, '1, '1, '1, '1, '1);
    wait_done();
    check_output(3, 9, 32'h0002_0007, 32'h000A_0014, 32'hFFFE_FFF9, 32'h0006_0006);
    handshake();
    check("hold_out4", out4, 32'h000A_0014);

    // Abort during step 5
    apply_stimulus(9, 8, 7, 6, 5, 4, 3, 2);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    abort = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_valid", {31'b0, seen}, 32'd0);
    apply_stimulus(2, 3, 4, 5, 10, 7, 1, 6);
    wait_done();
    check_output(15, 27, 12, 112, 32'hFFFF_FFFD, 30);
    handshake();

    // Asynchronous reset during step 7
    apply_stimulus(32'h0001_0000, 32'h0001_0000, 1, 2, 10, 7, 1, 6);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_output('0, '0, '0, '0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(2, 3, 4, 5, 10, 7, 1, 6);
    wait_done();
    check_output(15, 27, 12, 112, 32'hFFFF_FFFD, 30);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
